vic_sound_n: RTL and testbench
==============================

# vic_sound_n

Parametrised successor to the fixed four-voice VIC sound generator: NUM_TONE square-wave tone voices plus one LFSR noise voice, a 4-bit master volume and a registered mixed output. It sits beside the CPU bus in the VIC-20 top level. The top level decodes the $900A–$900E write strobes onto `wr_en/wr_addr`, and `audio_out` drives the audio DAC pins. New relative to the current block:

- per-voice enable with phase restart;
- glitch-free frequency update;
- a guaranteed non-lockup noise LFSR;
- arbitrary voice count.

## Interface
- NUM_TONE, 3, number of tone voices (1–6); voice i is one octave above voice i-1
- PRE_SHIFT, 4, base prescale: voice i ticks every 2^(PRE_SHIFT+NUM_TONE-1-i) `ena4` pulses
- OUT_W, 6, output width; must be ≥ clog2((NUM_TONE+1)*15+1)
- ADDR_W, derived, clog2(NUM_TONE+2)
- clk  in  1  system clock (25 MHz)
- reset_n  in  1  synchronous, active-low reset
- ena4  in  1  one-cycle clock-enable, 4× CPU rate; all sound timing advances only on it
- wr_en  in  1  register write strobe, one cycle
- wr_addr  in  ADDR_W  register select:
  - 0..NUM_TONE-1: tone voices
  - NUM_TONE: noise voice
  - NUM_TONE+1: volume
- wr_data  in  8  write data
- audio_out  out  OUT_W  unsigned mixed sample, registered
- voice_active  out  NUM_TONE+1  per-voice enable bits (bit NUM_TONE = noise), registered

## Operation
- **Voice register:**
  - bit7 = enable E.
  - bits6:0 = frequency F.
  - The register is written on `wr_en` regardless of `ena4`.
- **Volume register:**
  - bits3:0 = V.
  - Bits 7:4 are ignored.
- **Prescaler:**
  - One free-running counter, PRE_SHIFT+NUM_TONE bits, increments on `ena4`.
  - Voice i tick = `ena4` & (low PRE_SHIFT+NUM_TONE-1-i counter bits all ones).
  - The noise voice ticks with voice NUM_TONE-1.
- **Tone voice:**
  - On each tick with E=1, the 7-bit counter increments.
  - When the counter is 127, it reloads the active F and toggles the output bit.
  - Half-period = 128-F ticks. F=127 toggles every tick.
- **Frequency latch:**
  - A written F is stored in a pending register.
  - The active F takes the pending value only at reload. No mid-period glitches.
- **Enable transitions:**
  - E 1→0: output forced to 0 and counter held.
  - E 0→1: counter loaded with the new F immediately and output set to 0 (phase restart).
- **Noise voice:**
  - Same counter logic.
  - On each toggle event, a 16-bit Fibonacci LFSR shifts left with feedback = b15^b13^b12^b10.
  - Output = LFSR b0 while E=1.
  - If the LFSR ever reads 0, it reloads 16'hACE1 on the next shift.
- **Mixer:**
  - sum = popcount(channel output bits).
  - `audio_out` = sum × V, zero-extended to OUT_W.
  - No clipping is possible given the OUT_W rule.

## Timing
- **Reset** (`reset_n`=0 at a clk edge) clears:
  - all E, F, pending F, V, counters and output bits;
  - the prescaler;
  - `audio_out` = 0 and `voice_active` = 0.
  - LFSR = 16'hACE1.
  - Reset mid-period discards all phase.
- **Write latency:** a register is visible one cycle after `wr_en`. `voice_active` updates in that same cycle.
- **Channel latency:** a channel output bit changes in the cycle after its tick.
- **Output latency:** `audio_out` reflects channel bits and V one cycle later. Write to output = 2 cycles for V changes.
- **Simultaneous write and reload on the same voice:** reload uses the pre-write pending F; the new F applies at the following reload.
- **Simultaneous disable and toggle:** disable wins; output = 0.
- **Simultaneous enable-write and tick:** the restart wins; the tick is ignored.
- **`ena4` held low:** all counters frozen; writes still land; `audio_out` stays stable except for V/E changes.
- **Out-of-range `wr_addr`** (> NUM_TONE+1): ignored.

## Structure
- **Package `vic_sound_pkg`** holds:
  - LFSR seed 16'hACE1 and the tap mask;
  - register field positions (E bit, F range, V range);
  - a function computing ADDR_W/min OUT_W from NUM_TONE.
- **Sub-module `vic_sound_voice`** (counter, pending/active F, enable edge, toggle-event output) is instantiated NUM_TONE+1 times.
  - The top wraps the noise instance's toggle event with the LFSR.
- The prescaler, register decode and mixer live in the top.

## Test plan
- **Reset:** assert `reset_n`=0 after random writes → next cycle `audio_out`=0, `voice_active`=0, LFSR=16'hACE1.
- **Tone period:** defaults, `ena4` every cycle, write addr0=0xFE, addr4=0x0F → voice 0 toggles every 128 `ena4`; `audio_out` alternates 0/15.
- **Octave spacing:** addr0=0xFE, addr2=0xFE → voice 2 toggles every 32 `ena4` (4× voice 0); `audio_out` ∈ {0,15,30}.
- **Glitch-free update:** with voice 1 running at F=0x40, write 0xFF mid-period → current half-period completes at 64 ticks, then 1-tick half-periods.
- **Enable edges:** write 0x00 then 0x90 to addr2 between ticks → output 0 at once, restarts phase at counter=0x10; disable coincident with a toggle → output stays 0.
- **Noise:** addr3=0xFF, V=1 → `audio_out` follows LFSR b0 sequence from 0xACE1; force LFSR=0 by backdoor → reloads 0xACE1 on next shift; ≥65535 shifts show no lockup.

Source files
------------

// File: rtl/vic_sound_pkg.sv
// vic_sound_n shared constants and sizing helpers.
// LFSR seed/taps and register field positions.
package vic_sound_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int E_BIT = 7;
  localparam int F_MSB = 6;
  localparam int F_LSB = 0;
  localparam int F_W   = 7;
  localparam int V_MSB = 3;
  localparam int V_LSB = 0;

  function automatic int addr_w(input int n);
    return $clog2(n + 2);
  endfunction

  function automatic int min_out_w(input int n);
    return $clog2((n + 1) * 15 + 1);
  endfunction

endpackage

// File: rtl/vic_sound_voice.sv
// One sound voice: 7-bit reload counter, pending F,
// enable edge handling and a square/toggle output.
module vic_sound_voice
  import vic_sound_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       en,
  output logic       sq,
  output logic       tog
);

  logic [F_W-1:0] cnt;
  logic [F_W-1:0] pend;
  logic           dis;
  logic           start;
  logic           wrap;

  assign dis   = wr & ~data[E_BIT];
  assign start = wr & data[E_BIT] & ~en;
  assign wrap  = &cnt;
  assign tog   = tick & en & wrap & ~dis;

  // Reload takes the pre-write pending F, so a new F
  // only ever starts on a period boundary.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      pend <= '0;
      en   <= 1'b0;
      sq   <= 1'b0;
    end else begin
      if (wr) pend <= data[F_MSB:F_LSB];
      if (dis) begin
        en <= 1'b0;
        sq <= 1'b0;
      end else if (start) begin
        en  <= 1'b1;
        sq  <= 1'b0;
        cnt <= data[F_MSB:F_LSB];
      end else if (tick && en) begin
        if (wrap) begin
          cnt <= pend;
          sq  <= ~sq;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vic_sound_n.sv
// VIC sound generator: NUM_TONE tone voices, one LFSR
// noise voice, 4-bit master volume, registered mix.
module vic_sound_n
  import vic_sound_pkg::*;
#(
  parameter int NUM_TONE  = 3,
  parameter int PRE_SHIFT = 4,
  parameter int OUT_W     = 6,
  parameter int ADDR_W    = addr_w(NUM_TONE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena4,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [OUT_W-1:0]  audio_out,
  output logic [NUM_TONE:0] voice_active
);

  localparam int NV = NUM_TONE + 1;
  localparam int PW = PRE_SHIFT + NUM_TONE;

  logic [PW-1:0]    pre;
  logic [NV-1:0]    tick;
  logic [NV-1:0]    wr;
  logic [NV-1:0]    en;
  logic [NV-1:0]    sq;
  logic [NV-1:0]    tog;
  logic [NV-1:0]    ch;
  logic             wr_vol;
  logic [3:0]       vol;
  logic [15:0]      lfsr;
  logic [OUT_W-1:0] sum;
  logic             unused_bits;

  always_ff @(posedge clk) begin
    if (!reset_n) pre <= '0;
    else if (ena4) pre <= pre + 1'b1;
  end

  // Noise voice shares the slowest-mask tick of the top tone.
  for (genvar i = 0; i < NV; i++) begin : g_v
    localparam int K =
      PW - 1 - ((i == NUM_TONE) ? NUM_TONE - 1 : i);
    localparam logic [PW-1:0] MASK =
      PW'((64'd1 << K) - 64'd1);

    assign tick[i] = ena4 & ((pre & MASK) == MASK);
    assign wr[i]   = wr_en & (wr_addr == ADDR_W'(i));

    vic_sound_voice u_voice (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick[i]),
      .wr      (wr[i]),
      .data    (wr_data),
      .en      (en[i]),
      .sq      (sq[i]),
      .tog     (tog[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (tog[NUM_TONE]) begin
      lfsr <= (lfsr == '0) ? LFSR_SEED
            : {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign wr_vol = wr_en & (wr_addr == ADDR_W'(NUM_TONE + 1));

  always_ff @(posedge clk) begin
    if (!reset_n) vol <= '0;
    else if (wr_vol) vol <= wr_data[V_MSB:V_LSB];
  end

  assign ch = {en[NUM_TONE] & lfsr[0], sq[NUM_TONE-1:0]};

  always_comb begin
    sum = '0;
    for (int i = 0; i < NV; i++) sum = sum + OUT_W'(ch[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) audio_out <= '0;
    else audio_out <= sum * OUT_W'(vol);
  end

  assign voice_active = en;
  assign unused_bits  = ^{tog[NUM_TONE-1:0], sq[NUM_TONE]};

endmodule

// File: tb/tb_vic_sound_n.sv
// Randomised scoreboard bench for vic_sound_n against a
// countdown-based behavioural model of the voices.
module tb_vic_sound_n;

  localparam int NT = 3;
  localparam int PS = 4;
  localparam int OW = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ena4 = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [OW-1:0] audio_out;
  logic [NT:0]   voice_active;

  vic_sound_n #(
    .NUM_TONE  (NT),
    .PRE_SHIFT (PS),
    .OUT_W     (OW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ena4         (ena4),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .audio_out    (audio_out),
    .voice_active (voice_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] au;
    logic [NT:0]   va;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_vec = 0;
  int   n_err = 0;

  // Model: ticks remaining to next toggle per voice.
  int        rem  [NT+1];
  bit        sq   [NT+1];
  bit        en   [NT+1];
  int        pend [NT+1];
  bit [15:0] lf;
  int        pre;
  int        vol;

  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    if (s == 16'h0000) return 16'hACE1;
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic bit m_tick(input int v, input bit e4);
    int k;
    k = PS + NT - 1 - ((v == NT) ? NT - 1 : v);
    return e4 && (((pre + 1) % (1 << k)) == 0);
  endfunction

  function automatic int m_mix();
    int s;
    s = 0;
    for (int v = 0; v < NT; v++) s += int'(sq[v]);
    if (en[NT] && lf[0]) s += 1;
    return s * vol;
  endfunction

  function automatic void m_step(input bit rst, input bit e4,
                                 input bit w, input int a,
                                 input int d);
    bit wv;
    bit tg;
    int f;
    if (rst) begin
      for (int v = 0; v <= NT; v++) begin
        rem[v] = 0; sq[v] = 0; en[v] = 0; pend[v] = 0;
      end
      lf = 16'hACE1; pre = 0; vol = 0;
      return;
    end
    f = d % 128;
    for (int v = 0; v <= NT; v++) begin
      wv = w && (a == v);
      tg = 0;
      if (wv && d < 128) begin
        en[v] = 0; sq[v] = 0; pend[v] = f;
      end else if (wv && !en[v]) begin
        en[v] = 1; sq[v] = 0; rem[v] = 128 - f; pend[v] = f;
      end else begin
        if (m_tick(v, e4) && en[v]) begin
          rem[v]--;
          if (rem[v] == 0) begin
            tg = 1; sq[v] = !sq[v]; rem[v] = 128 - pend[v];
          end
        end
        if (wv) pend[v] = f;
      end
      if (v == NT && tg) lf = lfsr_next(lf);
    end
    if (w && a == NT + 1) vol = d % 16;
    if (e4) pre = (pre + 1) % (1 << (PS + NT));
  endfunction

  task automatic cyc(input bit rst, input bit e4, input bit w,
                     input int a, input int d);
    exp_t e;
    @(negedge clk);
    reset_n = !rst;
    ena4    = e4;
    wr_en   = w;
    wr_addr = AW'(a);
    wr_data = 8'(d);
    e.au = rst ? '0 : OW'(m_mix());
    m_step(rst, e4, w, a, d);
    for (int v = 0; v <= NT; v++) e.va[v] = en[v];
    sb.push_back(e);
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++)
      cyc(0, (mode == 2) ? bit'($urandom % 2) : bit'(mode), 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(0, 1, 1, a, d);
  endtask

  // Advance until the next edge is a tick (and optionally a toggle).
  task automatic wait_event(input int v, input bit need_tog);
    bit hit;
    hit = 0;
    for (int i = 0; i < 5000; i++) begin
      if (m_tick(v, 1) && (!need_tog || (en[v] && rem[v] == 1))) begin
        hit = 1;
        break;
      end
      cyc(0, 1, 0, 0, 0);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_event v%0d: got timeout want event", v);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      n_vec++;
      if (audio_out !== me.au) begin
        n_err++;
        $display("FAIL audio_out t=%0t: got %0d want %0d",
                 $time, audio_out, me.au);
      end
      n_vec++;
      if (voice_active !== me.va) begin
        n_err++;
        $display("FAIL voice_active t=%0t: got %b want %b",
                 $time, voice_active, me.va);
      end
    end
  end

  initial begin
    bit r;
    bit w;
    bit e4;
    int a;
    int d;

    repeat (3) cyc(1, 0, 0, 0, 0);

    wr(4, 'h0F); wr(0, 'hFE); run(600, 1);
    wr(2, 'hFE); run(300, 1);

    wr(0, 'h00); wr(2, 'h00); wr(1, 'hC0);
    run(1000, 1); wr(1, 'hFF); run(1500, 1);

    wr(1, 'h00); wr(2, 'hFF); run(100, 1);
    wr(2, 'h00); run(20, 2); wr(2, 'h90); run(400, 2);

    wr(2, 'hFF); wait_event(2, 1); cyc(0, 1, 1, 2, 'h7F); run(40, 1);
    wait_event(2, 0); cyc(0, 1, 1, 2, 'hFF); run(100, 1);
    wr(2, 'hF0); run(300, 1);
    wait_event(2, 1); cyc(0, 1, 1, 2, 'hFF); run(200, 1);

    cyc(0, 0, 1, 4, 'h07); run(50, 0); cyc(0, 0, 1, 2, 'h00);
    run(10, 0);

    wr(0, 'h00); wr(2, 'h00); wr(4, 'h01); wr(3, 'hFF);
    run(8000, 1);
    wr(4, 'hF5); run(500, 1);

    for (int i = 0; i < 20000; i++) begin
      r  = ($urandom % 3000) == 0;
      w  = ($urandom % 8) == 0;
      e4 = ($urandom % 4) != 0;
      a  = int'($urandom % 8);
      d  = int'($urandom % 256);
      if ($urandom % 2) d = (d & 'h8F) | 'h70;
      cyc(r, e4, w, a, d);
    end

    wr(0, 'hFF); wr(3, 'hFF); wr(4, 'h0F); run(30, 1);
    cyc(1, 1, 0, 0, 0); run(5, 1);

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
